// File: rtl/sprite_pkg.sv
// Sprite finder shared definitions: widths, FSM states
// and the fixed sprite position table.
package sprite_pkg;

  localparam int unsigned NUM_SPRITES = 64;
  localparam int unsigned IDX_W       = 6;
  localparam int unsigned POS_W       = 10;
  localparam int unsigned CNT_W       = 3;
  localparam int unsigned SLOTS       = 4;

  localparam logic [IDX_W-1:0] NULL_SPRITE = 6'd63;
  localparam logic [IDX_W-1:0] LAST_IDX    = 6'd62;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Column position: eight sprites per row, 72 px apart.
  function automatic logic [POS_W-1:0] sprite_x(
    input logic [IDX_W-1:0] i
  );
    return POS_W'(i[2:0]) * 10'd72;
  endfunction

  // Row position: eight rows, 56 px apart.
  function automatic logic [POS_W-1:0] sprite_y(
    input logic [IDX_W-1:0] i
  );
    return POS_W'(i[5:3]) * 10'd56;
  endfunction

endpackage

// File: rtl/sprite_finder_position_hit_cmp.sv
// Bounding-box test of one pixel against one sprite.
// Sums are one bit wider than positions, so no wrap.
module sprite_hit_cmp
  import sprite_pkg::*;
#(
  parameter int unsigned SPRITE_W = 16,
  parameter int unsigned SPRITE_H = 16
) (
  input  logic [POS_W-1:0] h,
  input  logic [POS_W-1:0] v,
  input  logic [POS_W-1:0] x,
  input  logic [POS_W-1:0] y,
  output logic             hit
);

  localparam int unsigned EW = POS_W + 1;
  localparam logic [EW-1:0] W_EXT = EW'(SPRITE_W);
  localparam logic [EW-1:0] H_EXT = EW'(SPRITE_H);

  logic [EW-1:0] h_e;
  logic [EW-1:0] v_e;
  logic [EW-1:0] x_e;
  logic [EW-1:0] y_e;

  assign h_e = {1'b0, h};
  assign v_e = {1'b0, v};
  assign x_e = {1'b0, x};
  assign y_e = {1'b0, y};

  // Inclusive left/top edge, exclusive right/bottom edge.
  always_comb begin
    hit = (h_e >= x_e) && (h_e < x_e + W_EXT) &&
          (v_e >= y_e) && (v_e < y_e + H_EXT);
  end

endmodule

// File: rtl/sprite_finder_position.sv
// Sprite hit-finder: scans the table one entry per cycle
// and reports the first four sprites covering (H,V).
module sprite_finder_position
  import sprite_pkg::*;
#(
  parameter int unsigned SPRITE_W = 16,
  parameter int unsigned SPRITE_H = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active_finder_position,
  input  logic [POS_W-1:0] H_pos_in,
  input  logic [POS_W-1:0] V_pos_in,
  output logic             active_high_four,
  output logic [IDX_W-1:0] high_four [SLOTS-1:0]
);

  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] h_q, h_d;
  logic [POS_W-1:0] v_q, v_d;
  logic [IDX_W-1:0] slot_q [SLOTS-1:0];
  logic [IDX_W-1:0] slot_d [SLOTS-1:0];
  logic             pulse_q, pulse_d;
  logic             hit;

  sprite_hit_cmp #(
    .SPRITE_W(SPRITE_W),
    .SPRITE_H(SPRITE_H)
  ) u_cmp (
    .h  (h_q),
    .v  (v_q),
    .x  (sprite_x(idx_q)),
    .y  (sprite_y(idx_q)),
    .hit(hit)
  );

  // Next-state, slot fill and done pulse.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    h_d     = h_q;
    v_d     = v_q;
    slot_d  = slot_q;
    unique case (state_q)
      S_IDLE: begin
        if (active_finder_position) begin
          h_d     = H_pos_in;
          v_d     = V_pos_in;
          slot_d  = '{default: NULL_SPRITE};
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (hit) begin
          slot_d[cnt_q[1:0]] = idx_q;
          cnt_d = cnt_q + 3'd1;
        end
        if (cnt_d == 3'd4 || idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    pulse_d = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      pulse_q <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        slot_q[i] <= NULL_SPRITE;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      v_q     <= v_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < SLOTS; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign active_high_four = pulse_q;
  assign high_four        = slot_q;

endmodule

// File: tb/tb_sprite_finder_position.sv
// Self-checking bench for sprite_finder_position:
// default-size and saturated-size instances.
module tb_sprite_finder_position;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_d, req_s;
  logic [9:0] h_d, v_d, h_s, v_s;
  logic       pulse_d, pulse_s;
  logic [5:0] hf_d [3:0];
  logic [5:0] hf_s [3:0];

  int checks = 0;
  int errors = 0;
  int exp_slot [4];
  int exp_lat;

  always #5 clk = ~clk;

  sprite_finder_position #(
    .SPRITE_W(16),
    .SPRITE_H(16)
  ) dut_d (
    .clk                   (clk),
    .rst                   (rst),
    .active_finder_position(req_d),
    .H_pos_in              (h_d),
    .V_pos_in              (v_d),
    .active_high_four      (pulse_d),
    .high_four             (hf_d)
  );

  sprite_finder_position #(
    .SPRITE_W(1023),
    .SPRITE_H(1023)
  ) dut_s (
    .clk                   (clk),
    .rst                   (rst),
    .active_finder_position(req_s),
    .H_pos_in              (h_s),
    .V_pos_in              (v_s),
    .active_high_four      (pulse_s),
    .high_four             (hf_s)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: walk entries 0..62 in priority order.
  // Latency counts edges from the edge the request is driven after.
  task automatic model(input int h, input int v,
                       input int w, input int hh);
    int n;
    n = 0;
    for (int s = 0; s < 4; s++) exp_slot[s] = 63;
    exp_lat = 64;
    for (int i = 0; i < 63; i++) begin
      int x, y;
      x = (i % 8) * 72;
      y = (i / 8) * 56;
      if (n < 4 && h >= x && h < x + w && v >= y && v < y + hh) begin
        exp_slot[n] = i;
        n++;
        if (n == 4) exp_lat = i + 2;
      end
    end
  endtask

  function automatic logic pulse_of(input bit sat);
    return sat ? pulse_s : pulse_d;
  endfunction

  function automatic logic [5:0] slot_of(input bit sat, input int s);
    return sat ? hf_s[s] : hf_d[s];
  endfunction

  task automatic search(input bit sat, input int h, input int v,
                        input bit scramble, input string tag);
    int  edges;
    bit  got;
    model(h, v, sat ? 1023 : 16, sat ? 1023 : 16);
    @(posedge clk); #1;
    if (sat) begin
      req_s = 1'b1; h_s = 10'(h); v_s = 10'(v);
    end else begin
      req_d = 1'b1; h_d = 10'(h); v_d = 10'(v);
    end
    @(posedge clk); #1;
    req_s = 1'b0;
    req_d = 1'b0;
    if (scramble) begin
      h_d = 10'($urandom); v_d = 10'($urandom);
      h_s = 10'($urandom); v_s = 10'($urandom);
    end
    edges = 1;
    got   = 1'b0;
    while (edges < 200 && !got) begin
      @(posedge clk); #1;
      edges++;
      if (pulse_of(sat)) got = 1'b1;
    end
    chk($sformatf("%s pulse_seen", tag), 32'(got), 32'd1);
    chk($sformatf("%s latency", tag), 32'(edges), 32'(exp_lat));
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("%s slot%0d", tag, s),
          32'(slot_of(sat, s)), 32'(exp_slot[s]));
    end
    @(posedge clk); #1;
    chk($sformatf("%s pulse_one_cycle", tag), 32'(pulse_of(sat)), 32'd0);
  endtask

  initial begin
    int t0, gap;
    bit got;
    rst   = 1'b0;
    req_d = 1'b0; req_s = 1'b0;
    h_d = '0; v_d = '0; h_s = '0; v_s = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst pulse_d", 32'(pulse_d), 32'd0);
    chk("rst pulse_s", 32'(pulse_s), 32'd0);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("rst slot%0d", s), 32'(hf_d[s]), 32'd63);
    end
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle pulse", 32'(pulse_d), 32'd0);
    chk("idle slot0", 32'(hf_d[0]), 32'd63);

    search(1'b0, 10, 5, 1'b1, "single");
    search(1'b0, 16, 5, 1'b0, "edge_h16");
    search(1'b0, 15, 15, 1'b0, "edge_1515");
    search(1'b0, 72, 56, 1'b0, "edge_7256");
    search(1'b1, 600, 450, 1'b1, "saturate");

    repeat (4) @(posedge clk);
    #1;
    chk("hold_idle slot0", 32'(hf_d[0]), 32'd9);

    for (int k = 0; k < 12; k++) begin
      int i, h, v;
      i = $urandom_range(0, 62);
      h = (i % 8) * 72 + $urandom_range(0, 17) - 1;
      v = (i / 8) * 56 + $urandom_range(0, 17) - 1;
      if (h < 0) h = 0;
      if (v < 0) v = 0;
      search(1'b0, h, v, k[0], $sformatf("rnd_d%0d", k));
    end
    for (int k = 0; k < 6; k++) begin
      search(1'b1, $urandom_range(0, 1023), $urandom_range(0, 1023),
             1'b1, $sformatf("rnd_s%0d", k));
    end

    // Held request: back-to-back searches.
    @(posedge clk); #1;
    req_d = 1'b1; h_d = 10'd80; v_d = 10'd60;
    got = 1'b0; t0 = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(posedge clk); #1;
      if (pulse_d) begin got = 1'b1; t0 = c; end
    end
    chk("hold first_pulse", 32'(got), 32'd1);
    got = 1'b0; gap = 0;
    for (int c = 1; c < 200 && !got; c++) begin
      @(posedge clk); #1;
      if (pulse_d) begin got = 1'b1; gap = c; end
    end
    req_d = 1'b0;
    chk("hold second_pulse", 32'(got), 32'd1);
    chk("hold period", 32'(gap), 32'd65);
    chk("hold slot0", 32'(hf_d[0]), 32'd9);
    chk("hold slot1", 32'(hf_d[1]), 32'd63);
    repeat (70) @(posedge clk);
    #1;
    chk("hold stopped", 32'(pulse_d), 32'd0);

    // Reset in the middle of a scan.
    @(posedge clk); #1;
    req_d = 1'b1; h_d = 10'd10; v_d = 10'd5;
    @(posedge clk); #1;
    req_d = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("mid slot0_before", 32'(hf_d[0]), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst pulse", 32'(pulse_d), 32'd0);
    chk("mid_rst slot0", 32'(hf_d[0]), 32'd63);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (70) @(posedge clk);
    #1;
    chk("mid_rst no_pulse", 32'(pulse_d), 32'd0);
    search(1'b0, 80, 60, 1'b0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
